// File: rtl/sram_arbiter_pkg.sv
// Shared types and defaults for the two-master SRAM arbiter.
package sram_arbiter_pkg;

    localparam int unsigned CntW        = 4;
    localparam int unsigned DefMaxWait  = 4;
    localparam int unsigned DefMaxBurst = 8;

    typedef enum logic [1:0] {
        OwnerNone = 2'd0,
        OwnerCpu  = 2'd1,
        OwnerDma  = 2'd2
    } owner_e;

endpackage

// File: rtl/sram_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; used for DMA wait and burst tracking.
module sram_arbiter_sat_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] value_o,
    output logic             at_max_o
);

    logic [WIDTH-1:0] value_q, value_d;

    assign at_max_o = (value_q == WIDTH'(MAX));
    assign value_o  = value_q;

    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (inc_i && !at_max_o) begin
            value_d = value_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// CPU/DMA arbiter for a single-port SRAM: CPU priority with DMA starvation and burst-lock bounds.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_WAIT  = DefMaxWait,
    parameter int unsigned MAX_BURST = DefMaxBurst
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_lock,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] sram_ADDR,
    output logic [DATA_W-1:0] sram_DI,
    output logic              sram_EN,
    output logic              sram_WE,
    input  logic [DATA_W-1:0] sram_DO
);

    logic [CntW-1:0] wait_cnt, burst_cnt;
    logic            wait_at_max, burst_at_max;
    logic            lock_own_q, lock_own_d;
    owner_e          rd_owner_q, rd_owner_d;

    // Grant selection; DMA override only when starved or holding an unexhausted lock.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!reset) begin
            if (dma_req && (wait_at_max || (lock_own_q && !burst_at_max))) begin
                dma_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (dma_req) begin
                dma_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        sram_EN   = cpu_gnt | dma_gnt;
        sram_WE   = 1'b0;
        sram_ADDR = '0;
        sram_DI   = '0;
        if (cpu_gnt) begin
            sram_WE   = cpu_we;
            sram_ADDR = cpu_addr;
            sram_DI   = cpu_wdata;
        end else if (dma_gnt) begin
            sram_WE   = dma_we;
            sram_ADDR = dma_addr;
            sram_DI   = dma_wdata;
        end
    end

    always_comb begin
        lock_own_d = lock_own_q;
        if (dma_gnt) begin
            lock_own_d = dma_lock;
        end else if (cpu_gnt || !dma_req) begin
            lock_own_d = 1'b0;
        end
    end

    always_comb begin
        rd_owner_d = OwnerNone;
        if (cpu_gnt && !cpu_we) begin
            rd_owner_d = OwnerCpu;
        end else if (dma_gnt && !dma_we) begin
            rd_owner_d = OwnerDma;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_own_q <= 1'b0;
            rd_owner_q <= OwnerNone;
        end else begin
            lock_own_q <= lock_own_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    always_comb begin
        cpu_rvalid = (rd_owner_q == OwnerCpu);
        dma_rvalid = (rd_owner_q == OwnerDma);
        cpu_rdata  = cpu_rvalid ? sram_DO : '0;
        dma_rdata  = dma_rvalid ? sram_DO : '0;
    end

    sram_arbiter_sat_counter #(
        .WIDTH(CntW),
        .MAX  (MAX_WAIT)
    ) u_wait_cnt (
        .clk_i   (clk),
        .rst_i   (reset),
        .inc_i   (dma_req && !dma_gnt),
        .clr_i   (!dma_req || dma_gnt),
        .value_o (wait_cnt),
        .at_max_o(wait_at_max)
    );

    // Burst only counts while the CPU is actually being held off.
    sram_arbiter_sat_counter #(
        .WIDTH(CntW),
        .MAX  (MAX_BURST)
    ) u_burst_cnt (
        .clk_i   (clk),
        .rst_i   (reset),
        .inc_i   (dma_gnt && dma_lock && cpu_req),
        .clr_i   (!lock_own_d),
        .value_o (burst_cnt),
        .at_max_o(burst_at_max)
    );

    sat_a : assert property (@(posedge clk) disable iff (reset)
        (wait_cnt <= CntW'(MAX_WAIT)) && (burst_cnt <= CntW'(MAX_BURST)));

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised and directed bench for sram_arbiter against a behavioural arbitration model.
module tb_sram_arbiter;

    localparam int unsigned MaxWait  = 4;
    localparam int unsigned MaxBurst = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
    logic [15:0] dma_addr;
    logic [31:0] dma_wdata, dma_rdata;
    logic [15:0] sram_ADDR;
    logic [31:0] sram_DI, sram_DO;
    logic        sram_EN, sram_WE;

    sram_arbiter #(
        .ADDR_W   (16),
        .DATA_W   (32),
        .MAX_WAIT (MaxWait),
        .MAX_BURST(MaxBurst)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata (cpu_rdata),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_lock  (dma_lock),
        .dma_gnt   (dma_gnt),
        .dma_rvalid(dma_rvalid),
        .dma_rdata (dma_rdata),
        .sram_ADDR (sram_ADDR),
        .sram_DI   (sram_DI),
        .sram_EN   (sram_EN),
        .sram_WE   (sram_WE),
        .sram_DO   (sram_DO)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    always @(posedge clk) begin
        if (sram_EN) begin
            if (sram_WE) mem[sram_ADDR[7:0]] <= sram_DI;
            else         sram_DO <= mem[sram_ADDR[7:0]];
        end
    end

    // Model state: consecutive denials, lock ownership, locked beats under contention, pending read.
    int          m_wait, m_burst, m_rd;
    bit          m_lock;
    logic [31:0] m_rdata;

    // {cpu_gnt, dma_gnt, EN, WE, cpu_rvalid, dma_rvalid, ADDR, DI, cpu_rdata, dma_rdata}
    logic [117:0] obs_v, exp_v;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_reset();
        m_wait  = 0;
        m_burst = 0;
        m_rd    = 0;
        m_lock  = 0;
        m_rdata = '0;
    endtask

    task automatic step(input logic c_req, input logic c_we, input logic [15:0] c_addr,
                        input logic [31:0] c_wd, input logic d_req, input logic d_we,
                        input logic [15:0] d_addr, input logic [31:0] d_wd, input logic d_lock);
        bit          cg, dg, we;
        logic [15:0] a;
        logic [31:0] w;
        cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
        dma_req = d_req; dma_we = d_we; dma_addr = d_addr; dma_wdata = d_wd; dma_lock = d_lock;
        cg = 0;
        dg = 0;
        if (d_req && (m_wait == MaxWait || (m_lock && m_burst < MaxBurst))) dg = 1;
        else if (c_req) cg = 1;
        else if (d_req) dg = 1;
        we = cg ? c_we : (dg ? d_we : 1'b0);
        a  = cg ? c_addr : (dg ? d_addr : 16'h0);
        w  = cg ? c_wd : (dg ? d_wd : 32'h0);
        exp_v = {cg, dg, cg | dg, we, m_rd == 1, m_rd == 2, a, w,
                 (m_rd == 1) ? m_rdata : 32'h0, (m_rd == 2) ? m_rdata : 32'h0};
        @(negedge clk);
        obs_v = {cpu_gnt, dma_gnt, sram_EN, sram_WE, cpu_rvalid, dma_rvalid, sram_ADDR, sram_DI,
                 cpu_rdata, dma_rdata};
        m_rd = 0;
        if (cg || dg) begin
            if (we) ref_mem[a[7:0]] = w;
            else begin
                m_rdata = ref_mem[a[7:0]];
                m_rd    = cg ? 1 : 2;
            end
        end
        m_wait = (d_req && !dg) ? ((m_wait < MaxWait) ? m_wait + 1 : m_wait) : 0;
        if (dg) m_lock = d_lock;
        else if (cg || !d_req) m_lock = 0;
        if (!m_lock) m_burst = 0;
        else if (dg && d_lock && c_req && m_burst < MaxBurst) m_burst = m_burst + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = 16'($urandom);
            cpu_wdata = $urandom;
            dma_req = 1'($urandom); dma_we = 1'($urandom); dma_addr = 16'($urandom);
            dma_wdata = $urandom; dma_lock = 1'($urandom);
            @(negedge clk);
            n_checks++;
            if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, sram_EN, sram_WE} !== 6'b0 ||
                sram_ADDR !== 16'h0 || sram_DI !== 32'h0 || cpu_rdata !== 32'h0 ||
                dma_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got gnt=%b%b rv=%b%b en=%b we=%b addr=%h di=%h, required all zero",
                         i, cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, sram_EN, sram_WE,
                         sram_ADDR, sram_DI);
            end
        end
        n_checks++;
        if ({dut.wait_cnt, dut.burst_cnt, dut.lock_own_q} !== 9'b0 || dut.rd_owner_q !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got wait=%0d burst=%0d lock=%b owner=%0d, required 0",
                     dut.wait_cnt, dut.burst_cnt, dut.lock_own_q, dut.rd_owner_q);
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        idle();
        n_checks++;
        if (obs_v !== exp_v || obs_v !== 118'h0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h required %h", obs_v, exp_v);
        end
    endtask

    task automatic test_cpu_only();
        logic [5:0] ctl [3];
        ctl[0] = 6'b101100;
        ctl[1] = 6'b101000;
        ctl[2] = 6'b000010;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) step(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
            else if (i == 1) step(1'b1, 1'b0, 16'h0010, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
            else idle();
            n_checks++;
            if (obs_v !== exp_v || obs_v[117:112] !== ctl[i]) begin
                n_fail++;
                $display("FAIL cpu_only[%0d]: got %h required %h ctl %b", i, obs_v, exp_v, ctl[i]);
            end
        end
        n_checks++;
        if (obs_v[63:32] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL cpu_readback: got %h required deadbeef", obs_v[63:32]);
        end
    endtask

    task automatic test_contention();
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b0, 16'($urandom_range(0, 255)), $urandom,
                 1'b1, 1'b0, 16'($urandom_range(0, 255)), $urandom, 1'b0);
            n_checks++;
            if (obs_v !== exp_v || obs_v[117:116] !== ((i % 5 == 4) ? 2'b01 : 2'b10) ||
                obs_v[112] !== (i % 5 == 0 && i > 0)) begin
                n_fail++;
                $display("FAIL contention[%0d]: got %h required %h", i, obs_v, exp_v);
            end
        end
        idle();
    endtask

    task automatic test_lock_burst();
        for (int i = 0; i < 13; i++) begin
            step(1'b1, 1'b0, 16'($urandom_range(0, 255)), $urandom,
                 1'b1, 1'($urandom), 16'($urandom_range(0, 255)), $urandom, 1'b1);
            n_checks++;
            if (obs_v !== exp_v || obs_v[117:116] !== ((i >= 4 && i <= 11) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL lock_burst[%0d]: got %h required %h", i, obs_v, exp_v);
            end
        end
        idle();
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 16'h0, 32'h0,
                 1'b1, 1'($urandom), 16'($urandom_range(0, 255)), $urandom, 1'b1);
            n_checks++;
            if (obs_v !== exp_v || obs_v[117:116] !== 2'b01) begin
                n_fail++;
                $display("FAIL lock_unbounded[%0d]: got %h required %h", i, obs_v, exp_v);
            end
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [4];
        for (int k = 1; k <= 3; k++) begin
            d[k] = $urandom;
            step(1'b1, 1'b1, 16'(k), d[k], 1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
        end
        for (int j = 0; j < 4; j++) begin
            if (j == 0) step(1'b1, 1'b0, 16'h0001, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
            else if (j == 1) step(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 16'h0002, 32'h0, 1'b0);
            else if (j == 2) step(1'b1, 1'b0, 16'h0003, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
            else idle();
            n_checks++;
            if (obs_v !== exp_v || obs_v[113] !== (j == 1 || j == 3) || obs_v[112] !== (j == 2) ||
                (j == 1 && obs_v[63:32] !== d[1]) || (j == 2 && obs_v[31:0] !== d[2]) ||
                (j == 3 && obs_v[63:32] !== d[3])) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %h required %h", j, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_wait_restart();
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b1, 16'($urandom_range(0, 255)), $urandom,
                 (i != 3), 1'b1, 16'($urandom_range(0, 255)), $urandom, 1'b0);
            n_checks++;
            if (obs_v !== exp_v || obs_v[117:116] !== ((i == 8) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL wait_restart[%0d]: got %h required %h", i, obs_v, exp_v);
            end
        end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 30),
                 16'($urandom), $urandom,
                 1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 30),
                 16'($urandom), $urandom, 1'($urandom));
            n_checks++;
            if (obs_v !== exp_v || (obs_v[113] && obs_v[112])) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h required %h", i, obs_v, exp_v);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_read();
        step(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 16'h0042, 32'h0, 1'b0);
        n_checks++;
        if (obs_v !== exp_v || obs_v[116] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_read_grant: got %h required %h", obs_v, exp_v);
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if (dma_rvalid !== 1'b0 || dma_rdata !== 32'h0 || dut.rd_owner_q !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_read_drop: got rvalid=%b rdata=%h required 0 0", dma_rvalid,
                     dma_rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        idle();
        n_checks++;
        if (obs_v !== exp_v || obs_v[113:112] !== 2'b00 ||
            {dut.wait_cnt, dut.burst_cnt, dut.lock_own_q} !== 9'b0) begin
            n_fail++;
            $display("FAIL mid_read_after: got %h wait=%0d burst=%0d required %h and zero counters",
                     obs_v, dut.wait_cnt, dut.burst_cnt, exp_v);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        sram_DO = 32'h0;
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0; dma_wdata = 32'h0; dma_lock = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_cpu_only();
        test_contention();
        test_lock_burst();
        test_back_to_back();
        test_wait_restart();
        test_random();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
